// File: rtl/acq_sequencer_if.sv
// Camera controller link: command byte out, busy flags back.
// Busy flags: frame_req and cmd_start_training active-high, CS_n active-low.
interface acq_sequencer_if;
  logic [7:0] cam_ctrl;
  logic       frame_req;
  logic       cmd_start_training;
  logic       CS_n;

  modport master (
    output cam_ctrl,
    input  frame_req,
    input  cmd_start_training,
    input  CS_n
  );

  modport slave (
    input  cam_ctrl,
    output frame_req,
    output cmd_start_training,
    output CS_n
  );
endinterface

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: train, periodic grab bursts, optional temperature reads.
// Define ACQ_SEQ_WATCHDOG_EN to build the acknowledge watchdog (sets seq_err).
module acq_sequencer (
  input  logic        clk_fix,
  input  logic        rst_fix,
  input  logic        seq_en,
  input  logic [15:0] interval,
  input  logic [3:0]  temp_every,
  input  logic        abort,
  acq_sequencer_if.master cam,
  output logic [2:0]  seq_state,
  output logic [15:0] burst_cnt,
  output logic        seq_err
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TRAIN_REQ  = 3'd1,
    TRAIN_WAIT = 3'd2,
    GAP        = 3'd3,
    GRAB_REQ   = 3'd4,
    GRAB_WAIT  = 3'd5,
    TEMP_REQ   = 3'd6,
    TEMP_WAIT  = 3'd7
  } state_t;

  state_t      state;
  logic        busy_q;
  logic        abort_q;
  logic        live;
  logic        ack_seen;
  logic [15:0] gap_cnt;
  logic [15:0] burst_q;
  logic [3:0]  temp_cnt;
  logic [7:0]  ctrl_q;

  logic        abort_rise;
  logic        in_wait;
  logic        done;
  logic [3:0]  temp_nxt;
  logic        temp_hit;
  logic [15:0] gap_load;
  logic        wd_fire;
  logic        err_q;

  assign abort_rise = abort & ~abort_q;
  assign in_wait    = (state == TRAIN_WAIT) |
                      (state == GRAB_WAIT)  |
                      (state == TEMP_WAIT);
  assign done       = in_wait & ack_seen & ~busy_q;
  assign temp_nxt   = temp_cnt + 4'd1;
  assign temp_hit   = (state == GRAB_WAIT) &&
                      (temp_every != 4'd0) &&
                      (temp_nxt == temp_every);
  assign gap_load   = (interval == 16'd0) ? 16'd1 : interval;

`ifdef ACQ_SEQ_WATCHDOG_EN
  logic [4:0] wd_cnt;

  // Timeout on the 16th wait cycle without an acknowledge.
  assign wd_fire = in_wait & ~ack_seen & ~busy_q &
                   (wd_cnt == 5'd15);

  always_ff @(posedge clk_fix or posedge rst_fix) begin
    if (rst_fix) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (!in_wait || ack_seen || busy_q)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 5'd1;
      if (wd_fire && !abort_rise)
        err_q <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign err_q   = 1'b0;
`endif

  always_ff @(posedge clk_fix or posedge rst_fix) begin
    if (rst_fix) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      abort_q  <= 1'b0;
      live     <= 1'b0;
      ack_seen <= 1'b0;
      gap_cnt  <= '0;
      burst_q  <= '0;
      temp_cnt <= '0;
      ctrl_q   <= '0;
    end else begin
      busy_q  <= cam.frame_req | cam.cmd_start_training | ~cam.CS_n;
      abort_q <= abort;
      live    <= 1'b1;
      ctrl_q  <= '0;
      if (abort_rise) begin
        state    <= IDLE;
        ctrl_q   <= 8'h80;
        temp_cnt <= '0;
        gap_cnt  <= '0;
        ack_seen <= 1'b0;
      end else if (wd_fire) begin
        state    <= IDLE;
        ack_seen <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (seq_en && !busy_q && live && !err_q) begin
              state  <= TRAIN_REQ;
              ctrl_q <= 8'h08;
            end
          end
          TRAIN_REQ: begin
            state    <= TRAIN_WAIT;
            ack_seen <= 1'b0;
          end
          GRAB_REQ: begin
            state    <= GRAB_WAIT;
            ack_seen <= 1'b0;
          end
          TEMP_REQ: begin
            state    <= TEMP_WAIT;
            ack_seen <= 1'b0;
          end
          GAP: begin
            if (!seq_en) begin
              state   <= IDLE;
              gap_cnt <= '0;
            end else if (gap_cnt <= 16'd1) begin
              state   <= GRAB_REQ;
              ctrl_q  <= 8'h10;
              gap_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt - 16'd1;
            end
          end
          TRAIN_WAIT, GRAB_WAIT, TEMP_WAIT: begin
            if (!ack_seen && busy_q)
              ack_seen <= 1'b1;
            if (done) begin
              ack_seen <= 1'b0;
              if (state == GRAB_WAIT) begin
                burst_q  <= burst_q + 16'd1;
                temp_cnt <= temp_hit ? 4'd0 : temp_nxt;
              end
              if (!seq_en) begin
                state <= IDLE;
              end else if (temp_hit) begin
                state  <= TEMP_REQ;
                ctrl_q <= 8'h40;
              end else begin
                state   <= GAP;
                gap_cnt <= gap_load;
              end
            end
          end
        endcase
      end
    end
  end

  assign cam.cam_ctrl = ctrl_q;
  assign seq_state    = state;
  assign burst_cnt    = burst_q;
  assign seq_err      = err_q;

endmodule

// File: doc/acq_sequencer.md
ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 The interface SHALL use one clock and an asynchronous, active-high reset. The ports SHALL be as follows (REQ-001 to REQ-011):
- clk_fix  in  1  20 MHz fixed clock; all logic on its rising edge.
- rst_fix  in  1  asynchronous, active-high reset.
REQ-002 seq_en  in  1  level; 1 = run the automatic acquisition schedule.
REQ-003 interval  in  16  idle cycles between grab bursts; 0 is treated as 1.
REQ-004 temp_every  in  4  temperature read after every Nth burst; 0 = never.
REQ-005 abort  in  1  level; its rising edge aborts the schedule.
REQ-006 frame_req, cmd_start_training  in  1 each  camera controller busy flags, active-high.
REQ-007 CS_n  in  1  camera controller temperature busy flag, active-low.
REQ-008 cam_ctrl  out  8  command byte to the camera controller, with these bits:
- [3] train;
- [4] grab;
- [6] temperature;
- [7] controller reset;
- all other bits always 0.
REQ-009 seq_state  out  3  current state encoding (REQ-013).
REQ-010 burst_cnt  out  16  count of completed grab bursts.
REQ-011 seq_err  out  1  sticky acknowledge-timeout flag.

Function
REQ-012 busy SHALL be defined as frame_req | cmd_start_training | ~CS_n, and SHALL be registered once before use.
REQ-013 The state machine SHALL have these states and encodings:
- IDLE = 0;
- TRAIN_REQ = 1;
- TRAIN_WAIT = 2;
- GAP = 3;
- GRAB_REQ = 4;
- GRAB_WAIT = 5;
- TEMP_REQ = 6;
- TEMP_WAIT = 7.
REQ-014 IDLE SHALL go to TRAIN_REQ on the first cycle with seq_en=1 and the registered busy flag = 0; otherwise it SHALL stay in IDLE.
REQ-015 Each *_REQ state SHALL last exactly one cycle, drive its command bit high for that cycle only, and then enter the matching *_WAIT state.
REQ-016 A *_WAIT state SHALL first wait for the registered busy flag to go 1 (acknowledge), then for it to go 0 (done); intermediate states are allowed.
REQ-017 When TRAIN_WAIT completes, the block SHALL enter GAP.
REQ-018 When GRAB_WAIT completes:
- burst_cnt SHALL increment, wrapping 0xFFFF -> 0;
- the internal 4-bit temp_cnt SHALL increment.
REQ-019 After GRAB_WAIT completes, the next state SHALL be:
- TEMP_REQ if temp_every != 0 and the new temp_cnt equals temp_every, with temp_cnt cleared to 0;
- GAP otherwise.
REQ-020 When TEMP_WAIT completes, the block SHALL enter GAP.
REQ-021 On entry to GAP, the gap counter SHALL load max(interval,1). It SHALL decrement each cycle, and at 1 the next state SHALL be GRAB_REQ. interval is sampled only on GAP entry.
REQ-022 If seq_en=0 while in GAP, the next state SHALL be IDLE.
REQ-023 If seq_en=0 while in a *_WAIT state, that wait SHALL complete first and the block SHALL then enter IDLE.
REQ-024 Re-enabling from IDLE SHALL always restart at TRAIN_REQ.
REQ-025 A rising edge of abort SHALL:
- drive cam_ctrl[7]=1 for exactly one cycle;
- force IDLE in that same cycle;
- clear temp_cnt and the gap counter;
- leave burst_cnt and seq_err unchanged.
REQ-026 abort SHALL have priority over every other transition and pulse, including a REQ pulse due in the same cycle; that REQ pulse SHALL be suppressed.
REQ-027 cam_ctrl SHALL be registered, with at most one bit high in any cycle.
REQ-028 Changing temp_every to a value <= the current temp_cnt SHALL delay the next temperature read until temp_cnt wraps, with no special handling.

Reset
REQ-029 While rst_fix=1, the block SHALL immediately hold:
- state = IDLE;
- cam_ctrl = 0x00;
- burst_cnt = 0;
- seq_err = 0;
- temp_cnt = 0;
- gap counter = 0;
- busy register = 0;
- abort edge register = 0.
REQ-030 A reset asserted mid-operation SHALL abandon any wait without issuing a cam_ctrl[7] pulse.
REQ-031 Reset deassertion SHALL take effect on the next clk_fix edge; the first possible REQ pulse SHALL occur no earlier than 2 cycles after deassertion.

Configuration
REQ-032 The macro ACQ_SEQ_WATCHDOG_EN SHALL control the acknowledge watchdog.
REQ-033 With ACQ_SEQ_WATCHDOG_EN defined:
- a 5-bit counter SHALL run in each *_WAIT state until acknowledge;
- if no acknowledge arrives within 16 cycles of REQ, seq_err SHALL be set (sticky until reset) and the state SHALL go to IDLE;
- seq_err=1 SHALL block the IDLE -> TRAIN_REQ transition.
REQ-034 With ACQ_SEQ_WATCHDOG_EN undefined, seq_err SHALL be tied to 0, no watchdog counter SHALL be built, and *_WAIT states SHALL wait indefinitely.

Verification
REQ-035 A bench SHALL cover these directed scenarios:
- seq_en=1, interval=4, temp_every=0, controller model acknowledges in 2 cycles, busy lasts 11 cycles -> cam_ctrl=0x08 once, then 0x10 pulses spaced 4 gap cycles + wait, burst_cnt increments per burst, 0x40 never issued.
- temp_every=3 -> a 0x40 pulse follows bursts 3, 6, 9, and GAP follows each TEMP_WAIT.
- abort rises during GRAB_WAIT -> cam_ctrl=0x80 for exactly 1 cycle, seq_state=0 on the next cycle, burst_cnt unchanged.
- seq_en falls in GAP with 3 cycles left -> IDLE next cycle and no 0x10 pulse; seq_en falls in GRAB_WAIT -> burst completes, burst_cnt+1, then IDLE.
- Watchdog build, busy stuck 0 after 0x10 -> seq_err=1 at REQ+17 cycles, IDLE, no further pulses until rst_fix; non-watchdog build -> stays in GRAB_WAIT forever.
- interval=0 and burst_cnt preset near 0xFFFF -> GAP lasts 1 cycle; burst_cnt wraps to 0; rst_fix pulsed mid-TEMP_WAIT -> all outputs 0 asynchronously, no 0x80 pulse.
